dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-access controller sitting directly upstream of the single-core data memory (12-bit address, 17-bit write bus, 12-bit synchronous read port).
- Converts core load/store requests into correctly timed memory write-enable, address and write-data signals.
- Supports single-word stores and 1–4 word pipelined burst loads at consecutive addresses, used for matrix row fetches.
- Registers returned read data and qualifies it with a per-word valid strobe.

Parameters:
- N, 17, write-data bus width (bus-side width); only bits [11:0] are stored by memory
- AW, 12, address width; memory depth 2^AW words
- DW, 12, read-data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request, sampled only when busy=0
- we_req  in  1  1 = store, 0 = load; sampled with req
- addr_in  in  AW  start address; sampled with req
- len_in  in  2  load burst length minus 1 (0..3 → 1..4 words); ignored for stores
- wdata_in  in  N  store data; sampled with req
- busy  out  1  high while an accepted access is in progress; req ignored while high
- rvalid  out  1  one-cycle strobe per returned load word
- rdata  out  DW  registered load data, valid when rvalid=1, holds value otherwise
- wdone  out  1  one-cycle strobe after the memory commits a store
- mem_we  out  1  memory write_en
- mem_addr  out  AW  memory addr
- mem_wdata  out  N  memory datain
- mem_rdata  in  DW  memory dataout (registered in memory, 1-cycle latency)

Behaviour:
- Reset (async, immediate): state=IDLE; busy, rvalid, wdone, mem_we = 0; mem_addr, mem_wdata, rdata = 0; burst counters = 0. Reset mid-burst or mid-store abandons the access. mem_we falls without waiting for a clock edge; the memory must not see a write at the next edge.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN.
- IDLE, req=1 at edge E0:
  - we_req=1 → WR: mem_addr<=addr_in, mem_wdata<=wdata_in (all N bits passed through), mem_we<=1.
  - we_req=0 → RD_ISSUE: mem_addr<=addr_in, issue count<=len_in, capture count<=len_in.
- WR (one cycle): mem_we=1; memory writes at E1. At E1: mem_we<=0, wdone<=1 for the cycle after E1, → IDLE. Store latency is 1 cycle from acceptance to commit.
- Load pipeline:
  - Address A presented in the cycle after E0; memory samples it at E1.
  - Controller captures mem_rdata into rdata at E2 with rvalid=1 in the following cycle.
  - Load latency: acceptance edge to rvalid = 2 edges.
- RD_ISSUE: at each edge, while issue count>0, mem_addr<=mem_addr+1 and issue count decrements. When it reaches 0, → RD_DRAIN.
- Address increment wraps modulo 2^AW: 4095+1 = 0, no error.
- Captures start one edge after the first address is issued and repeat every edge. Result: exactly len_in+1 consecutive rvalid cycles, words in ascending address order, no gaps.
- RD_DRAIN → IDLE at the edge that registers the final word, so busy=0 during the last rvalid cycle and a new req may be accepted there.
- busy = (state != IDLE), registered. A req arriving while busy=1 is dropped, not queued.
- mem_we is high only in WR; it is never high during loads.
- mem_addr holds its last value in IDLE.
- rvalid and wdone never assert in the same cycle.

Test Plan:
- Store: rst pulse; req=1, we_req=1, addr_in=0x008, wdata_in=17'h1_0005 → mem_we=1 exactly one cycle with mem_addr=0x008; wdone pulses one cycle later; memory ram[8]=0x005 (upper bits dropped).
- Single load: preload ram[0x048]=0x002; req, we_req=0, len_in=0, addr 0x048 → rvalid one cycle exactly 2 edges after acceptance, rdata=0x002; busy low in that cycle.
- Burst load: ram[200..203]=3,2,1,0; len_in=3, addr 200 → 4 back-to-back rvalid cycles with rdata 3,2,1,0; mem_we stays 0.
- Wrap and busy drop: len_in=1, addr 0xFFF → words from 0xFFF then 0x000; a second req during busy=1 produces no extra rvalid.
- Async reset mid-burst: assert rst between edges 2 and 3 of a 4-word burst → busy, rvalid, mem_we go 0 immediately; after release, no further rvalid without a new req.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: single-word stores and 1-4 word
// pipelined burst loads against a 1-cycle-latency synchronous memory.
module dmem_access_ctrl #(
    parameter int N  = 17,
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we_req,
    input  logic [AW-1:0] addr_in,
    input  logic [1:0]    len_in,
    input  logic [N-1:0]  wdata_in,
    output logic          busy,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          wdone,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state, state_n;
    logic [1:0]    issue_cnt, issue_n;
    logic [1:0]    cap_cnt, cap_n;
    logic          pend;
    logic [AW-1:0] addr_n;
    logic [N-1:0]  wdata_n;
    logic [DW-1:0] rdata_n;
    logic          we_n, rvalid_n, wdone_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        issue_n  = issue_cnt;
        cap_n    = cap_cnt;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        rdata_n  = rdata;
        we_n     = 1'b0;
        rvalid_n = 1'b0;
        wdone_n  = 1'b0;
        // pend marks that mem_rdata now holds a word the burst asked for
        if (pend) begin
            rdata_n  = mem_rdata;
            rvalid_n = 1'b1;
            if (cap_cnt != 2'd0) begin
                cap_n = cap_cnt - 2'd1;
            end
        end
        case (state)
            IDLE: begin
                if (req) begin
                    addr_n = addr_in;
                    if (we_req) begin
                        state_n = WR;
                        wdata_n = wdata_in;
                        we_n    = 1'b1;
                    end else begin
                        state_n = RD_ISSUE;
                        issue_n = len_in;
                        cap_n   = len_in;
                    end
                end
            end
            WR: begin
                wdone_n = 1'b1;
                state_n = IDLE;
            end
            RD_ISSUE: begin
                if (issue_cnt != 2'd0) begin
                    addr_n  = mem_addr + ADDR_ONE;
                    issue_n = issue_cnt - 2'd1;
                end else begin
                    state_n = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pend && cap_cnt == 2'd0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            rvalid    <= 1'b0;
            wdone     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            issue_cnt <= 2'd0;
            cap_cnt   <= 2'd0;
            pend      <= 1'b0;
        end else begin
            busy      <= (state_n != IDLE);
            rvalid    <= rvalid_n;
            wdone     <= wdone_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            rdata     <= rdata_n;
            issue_cnt <= issue_n;
            cap_cnt   <= cap_n;
            pend      <= (state == RD_ISSUE);
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural memory plus a reference
// array of expected contents; loads/stores checked cycle by cycle.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we_req;
    logic [11:0] addr_in;
    logic [1:0]  len_in;
    logic [16:0] wdata_in;
    logic        busy, rvalid, wdone, mem_we;
    logic [11:0] rdata, mem_addr, mem_rdata;
    logic [16:0] mem_wdata;

    logic [11:0] ram [4096];
    logic [11:0] ref_mem [4096];
    logic        pl_en;
    logic [11:0] pl_addr, pl_data;

    int checks = 0;
    int failures = 0;

    dmem_access_ctrl #(.N(17), .AW(12), .DW(12)) dut (
        .clk(clk), .rst(rst), .req(req), .we_req(we_req),
        .addr_in(addr_in), .len_in(len_in), .wdata_in(wdata_in),
        .busy(busy), .rvalid(rvalid), .rdata(rdata), .wdone(wdone),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write and registered read on the same edge
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata[11:0];
        mem_rdata <= ram[mem_addr];
    end

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 0; we_req = 0; addr_in = 0; len_in = 0; wdata_in = 0; pl_en = 0;
        pl_addr = 0; pl_data = 0;
        for (int i = 0; i < 4096; i++) preload(12'(i), 12'($urandom));
        @(negedge clk);
        checks++;
        if ({busy, rvalid, wdone, mem_we} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, rvalid, wdone, mem_we});
        end
        checks++;
        if (mem_addr !== 12'h0 || mem_wdata !== 17'h0 || rdata !== 12'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0",
                     mem_addr, mem_wdata, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_store(input logic [11:0] a, input logic [16:0] d);
        @(negedge clk);
        req = 1; we_req = 1; addr_in = a; wdata_in = d; len_in = 2'($urandom);
        @(negedge clk);
        req = 0;
        checks++;
        if (mem_we !== 1 || mem_addr !== a || mem_wdata !== d || busy !== 1
            || wdone !== 0) begin
            failures++;
            $display("FAIL store_issue got we=%b addr=%h wd=%h busy=%b wdone=%b exp 1 %h %h 1 0",
                     mem_we, mem_addr, mem_wdata, busy, wdone, a, d);
        end
        ref_mem[a] = d[11:0];
        @(negedge clk);
        checks++;
        if (mem_we !== 0 || wdone !== 1 || rvalid !== 0 || ram[a] !== ref_mem[a]) begin
            failures++;
            $display("FAIL store_commit got we=%b wdone=%b rvalid=%b ram=%h exp 0 1 0 %h",
                     mem_we, wdone, rvalid, ram[a], ref_mem[a]);
        end
        @(negedge clk);
        checks++;
        if (wdone !== 0 || mem_we !== 0) begin
            failures++;
            $display("FAIL store_after got wdone=%b we=%b exp 0 0", wdone, mem_we);
        end
    endtask

    task automatic run_load(input logic [11:0] a, input logic [1:0] l,
                            input bit inject, input string name);
        logic [11:0] exp_q [$];
        int got = 0;
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[(int'(a) + i) % 4096]);
        @(negedge clk);
        req = 1; we_req = 0; addr_in = a; len_in = l;
        @(negedge clk);
        req = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            if (inject && k == 1) begin
                req = 1; we_req = 0; addr_in = 12'($urandom); len_in = 2'd3;
            end
            if (inject && k == 2) req = 0;
            if (rvalid) begin
                checks++;
                if (got > int'(l) || k != 2 + got || rdata !== exp_q[got % 4]) begin
                    failures++;
                    $display("FAIL %s word%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                             name, got, k, rdata, 2 + got, exp_q[got % 4]);
                end
                if (got == int'(l)) begin
                    checks++;
                    if (busy !== 0) begin
                        failures++;
                        $display("FAIL %s last_busy got=%b exp=0", name, busy);
                    end
                end
                got++;
            end
            if (mem_we !== 0 || wdone !== 0) begin
                checks++; failures++;
                $display("FAIL %s we_during_load got we=%b wdone=%b exp 0 0",
                         name, mem_we, wdone);
            end
        end
        checks++;
        if (got != int'(l) + 1) begin
            failures++;
            $display("FAIL %s word_count got=%0d exp=%0d", name, got, int'(l) + 1);
        end
    endtask

    task automatic test_store();
        run_store(12'h008, 17'h1_0005);
        checks++;
        if (ram[12'h008] !== 12'h005) begin
            failures++;
            $display("FAIL store_trunc got=%h exp=005", ram[12'h008]);
        end
    endtask

    task automatic test_single_load();
        preload(12'h048, 12'h002);
        run_load(12'h048, 2'd0, 1'b0, "single_load");
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) preload(12'(200 + i), 12'(3 - i));
        run_load(12'd200, 2'd3, 1'b0, "burst");
    endtask

    task automatic test_wrap_drop();
        run_load(12'hFFF, 2'd1, 1'b1, "wrap_drop");
    endtask

    task automatic test_reset_mid();
        logic [11:0] old;
        @(negedge clk);
        req = 1; we_req = 0; addr_in = 12'h300; len_in = 2'd3;
        @(negedge clk);
        req = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if ({busy, rvalid, mem_we} !== 3'b0) begin
            failures++;
            $display("FAIL reset_mid_burst got=%b exp=000", {busy, rvalid, mem_we});
        end
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid !== 0) begin
                checks++; failures++;
                $display("FAIL reset_mid_burst_rvalid got=%b exp=0 cyc=%0d", rvalid, k);
            end
        end
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL reset_mid_burst_idle got busy=%b exp=0", busy);
        end
        old = ram[12'h123];
        @(negedge clk);
        req = 1; we_req = 1; addr_in = 12'h123; wdata_in = 17'h0_0ABC;
        @(negedge clk);
        req = 0;
        #2 rst = 1;
        #1;
        checks++;
        if (mem_we !== 0) begin
            failures++;
            $display("FAIL reset_mid_store got we=%b exp=0", mem_we);
        end
        @(negedge clk);
        rst = 0;
        checks++;
        if (ram[12'h123] !== old || wdone !== 0) begin
            failures++;
            $display("FAIL reset_mid_store_ram got=%h wdone=%b exp=%h 0",
                     ram[12'h123], wdone, old);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0)
                run_store(12'($urandom), 17'($urandom));
            else
                run_load(12'($urandom), 2'($urandom), 1'($urandom), "rand_load");
        end
        // loads over recently stored words near the top of memory
        run_store(12'hFFE, 17'h1_0777);
        run_load(12'hFFD, 2'd3, 1'b0, "store_then_load");
    endtask

    initial begin
        test_reset();
        test_store();
        test_single_load();
        test_burst();
        test_wrap_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
